// File: rtl/flash_pkg.sv
// Shared definitions for the flash read path: FSM states, command opcode and
// the bit budget of a single 0x03 read transaction.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_GAP
  } flash_state_e;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;
  localparam int TOTAL_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;
  localparam int BIT_CNT_W  = $clog2(TOTAL_BITS);

  // Flash returns the lowest-addressed byte first; it belongs in rdata[7:0].
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: one 64-bit shift register carries cmd+addr out on
// MOSI and collects the 32 data bits from MISO in its low half.
module spi_bit_engine
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic                 bit_end,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [DATA_BITS-1:0] rx_word
);

  localparam logic [4:0] HALF = 5'(CLK_DIV);
  localparam logic [4:0] LAST = 5'(2 * CLK_DIV - 1);

  logic                  active;
  logic [4:0]            phase;
  logic [TOTAL_BITS-1:0] sr;
  logic [TOTAL_BITS-1:0] sr_nxt;
  logic                  sample;
  logic                  in_data;
  logic                  last_bit;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    sr_nxt   = sr;
    in_data  = bit_cnt >= BIT_CNT_W'(CMD_BITS + ADDR_BITS);
    sample   = active && (phase == HALF);
    bit_end  = active && (phase == LAST);
    last_bit = bit_cnt == BIT_CNT_W'(TOTAL_BITS - 1);
    if (sample) sr_nxt = {sr[TOTAL_BITS-2:0], in_data & miso};
  end

  // With CLK_DIV=1 the final sample and the last bit end share an edge,
  // so the word is taken from the post-shift value.
  assign rx_word = sr_nxt[DATA_BITS-1:0];

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    // NOTE: reset clears every register explicitly; nothing relies on power-up values.
    if (rst) begin
      active  <= 1'b0;
      phase   <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      phase   <= '0;
      bit_cnt <= '0;
      sr      <= {FLASH_CMD_READ, addr, {DATA_BITS{1'b0}}};
      sck     <= 1'b0;
      mosi    <= FLASH_CMD_READ[7];
    end else if (active) begin
      sr <= sr_nxt;
      if (bit_end) begin
        phase <= '0;
        sck   <= 1'b0;
        if (last_bit) begin
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          mosi    <= sr_nxt[TOTAL_BITS-1];
        end
      end else begin
        phase <= phase + 5'd1;
        sck   <= (phase + 5'd1) >= HALF;
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Two-requester round-robin front end for 32-bit SPI flash reads (0x03).
// Owns the transaction FSM; bit timing lives in spi_bit_engine.
module flash_read_arbiter
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        flash_spi_cs_n,
  output logic        flash_spi_clk,
  output logic        flash_spi_mosi,
  input  logic        flash_spi_miso,
  output logic        flash_spi_wp_n,
  output logic        flash_spi_hold_n
);

  flash_state_e         state, state_nxt;
  logic                 grant;
  logic                 last_grant;
  logic                 winner;
  logic                 start;
  logic [3:0]           gap_cnt;
  logic                 bit_end;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] rx_word;

  assign start = (state == ST_IDLE) && (req != 2'b00);

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    winner = ~last_grant;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_grant;
    endcase
  end

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (winner ? addr1 : addr0),
    .miso    (flash_spi_miso),
    .sck     (flash_spi_clk),
    .mosi    (flash_spi_mosi),
    .bit_end (bit_end),
    .bit_cnt (bit_cnt),
    .rx_word (rx_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_CMD;
      ST_CMD:  if (bit_end && bit_cnt == BIT_CNT_W'(CMD_BITS - 1)) state_nxt = ST_ADDR;
      ST_ADDR: if (bit_end && bit_cnt == BIT_CNT_W'(CMD_BITS + ADDR_BITS - 1)) state_nxt = ST_DATA;
      ST_DATA: if (bit_end && bit_cnt == BIT_CNT_W'(TOTAL_BITS - 1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_GAP;
      ST_GAP:  if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    flash_spi_cs_n = !(state inside {ST_CMD, ST_ADDR, ST_DATA});
    busy           = state != ST_IDLE;
    done           = 2'b00;
    if (state == ST_DONE) done = grant ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      gap_cnt    <= '0;
      rdata      <= '0;
    end else begin
      if (start) begin
        grant      <= winner;
        last_grant <= winner;
      end
      if (state == ST_DATA && state_nxt == ST_DONE) rdata <= byte_swap32(rx_word);
      if (state == ST_DONE)                          gap_cnt <= 4'(CS_GAP - 1);
      else if (state == ST_GAP && gap_cnt != 4'd0)   gap_cnt <= gap_cnt - 4'd1;
    end
  end

  assign flash_spi_wp_n   = 1'b1;
  assign flash_spi_hold_n = 1'b1;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: a behavioural SPI flash per instance, a
// transaction-level expectation model and a cycle-level protocol monitor.
module tb_flash_read_arbiter;

  localparam int CD1  = 1;
  localparam int GAP1 = 2;
  localparam int CD3  = 3;
  localparam int GAP3 = 3;
  localparam int LAT1 = 1 + 128 * CD1;
  localparam int LAT3 = 1 + 128 * CD3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  req = 2'b00;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        busy, cs_n, sck, mosi, wp_n, hold_n;
  logic        miso = 1'b0;

  logic [1:0]  req3 = 2'b00;
  logic [23:0] addr0_3 = '0, addr1_3 = '0;
  logic [1:0]  done3;
  logic [31:0] rdata3;
  logic        busy3, cs3_n, sck3, mosi3, wp3_n, hold3_n;
  logic        miso3 = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  flash_read_arbiter #(.CLK_DIV(CD1), .CS_GAP(GAP1)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .done(done), .rdata(rdata), .busy(busy),
    .flash_spi_cs_n(cs_n), .flash_spi_clk(sck), .flash_spi_mosi(mosi),
    .flash_spi_miso(miso), .flash_spi_wp_n(wp_n), .flash_spi_hold_n(hold_n)
  );

  flash_read_arbiter #(.CLK_DIV(CD3), .CS_GAP(GAP3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .addr0(addr0_3), .addr1(addr1_3),
    .done(done3), .rdata(rdata3), .busy(busy3),
    .flash_spi_cs_n(cs3_n), .flash_spi_clk(sck3), .flash_spi_mosi(mosi3),
    .flash_spi_miso(miso3), .flash_spi_wp_n(wp3_n), .flash_spi_hold_n(hold3_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural flash: captures the first 32 MOSI bits on SCK rises, then
  // shifts flash_resp out MSB first, changing MISO on SCK falls.
  int          rise_cnt = 0, rise3_cnt = 0;
  logic [31:0] mosi_cap = '0, mosi3_cap = '0;
  logic [31:0] flash_resp = '0, flash_resp3 = '0;

  always @(negedge cs_n) rise_cnt = 0;
  always @(posedge sck) begin
    if (rise_cnt < 32) mosi_cap = {mosi_cap[30:0], mosi};
    rise_cnt++;
  end
  always @(negedge sck)
    if (rise_cnt >= 32 && rise_cnt < 64) miso = flash_resp[31 - (rise_cnt - 32)];

  always @(negedge cs3_n) rise3_cnt = 0;
  always @(posedge sck3) begin
    if (rise3_cnt < 32) mosi3_cap = {mosi3_cap[30:0], mosi3};
    rise3_cnt++;
  end
  always @(negedge sck3)
    if (rise3_cnt >= 32 && rise3_cnt < 64) miso3 = flash_resp3[31 - (rise3_cnt - 32)];

  // Protocol monitor, both instances, every cycle once out of the first reset.
  bit         armed = 1'b0;
  logic       prev_sck = 1'b0, prev_mosi = 1'b0, prev_sck3 = 1'b0, prev_mosi3 = 1'b0;
  logic [1:0] prev_done = '0, prev_done3 = '0;

  always @(negedge clk) begin
    if (armed && !rst) begin
      if (cs_n)             check("sck_low_when_cs_high", sck, 1'b0);
      if (sck && prev_sck)  check("mosi_stable_sck_high", mosi, prev_mosi);
      check("done_not_both", done == 2'b11, 1'b0);
      if (prev_done != 0)   check("done_single_cycle", done, 2'b00);
      if (cs3_n)            check("sck3_low_when_cs_high", sck3, 1'b0);
      if (sck3 && prev_sck3) check("mosi3_stable_sck_high", mosi3, prev_mosi3);
      check("done3_not_both", done3 == 2'b11, 1'b0);
      if (prev_done3 != 0)  check("done3_single_cycle", done3, 2'b00);
    end
    prev_sck   = sck;   prev_mosi  = mosi;  prev_done  = done;
    prev_sck3  = sck3;  prev_mosi3 = mosi3; prev_done3 = done3;
  end

  // Reference model state: who was served last.
  logic last_grant_m = 1'b1;

  // Called at a negedge. Returns the requester the model expected to win.
  task automatic run_txn(input logic [1:0] r, input logic [23:0] a0, input logic [23:0] a1,
                         input logic [31:0] resp, input bit hold, input bit drop_mid,
                         output logic w);
    int          n;
    int          k;
    logic [23:0] exp_addr;
    logic [31:0] exp_rd;
    w = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : !last_grant_m;
    exp_addr = w ? a1 : a0;
    for (int b = 0; b < 4; b++) exp_rd[8*b +: 8] = resp[8*(3-b) +: 8];
    flash_resp = resp;
    req = r; addr0 = a0; addr1 = a1;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    check("idle_wait_bound", n < 100, 1'b1);
    @(negedge clk);
    k = 1;
    check("cs_low_t1", cs_n, 1'b0);
    check("mosi_cmd_bit7_t1", mosi, 1'b0);
    check("busy_t1", busy, 1'b1);
    addr0 = 24'($urandom);
    addr1 = 24'($urandom);
    while (done == 2'b00 && k < 600) begin
      if (drop_mid && k == 5) req = 2'b00;
      @(negedge clk);
      k++;
    end
    check("done_latency", k, LAT1);
    check("done_grant", done, w ? 2'b10 : 2'b01);
    check("rdata", rdata, exp_rd);
    check("cs_high_in_done", cs_n, 1'b1);
    check("sck_low_in_done", sck, 1'b0);
    check("mosi_cmd_addr", mosi_cap, {8'h03, exp_addr});
    last_grant_m = w;
    if (!hold) req = 2'b00;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      check("cs_high_in_gap", cs_n, 1'b1);
      n++;
      @(negedge clk);
    end
    check("gap_length", n, GAP1);
    check("rdata_held", rdata, exp_rd);
  endtask

  task automatic run_txn3(input logic [23:0] a, input logic [31:0] resp);
    int          n;
    int          k;
    int          run;
    int          min_run;
    int          max_run;
    logic        cur;
    logic [31:0] exp_rd;
    for (int b = 0; b < 4; b++) exp_rd[8*b +: 8] = resp[8*(3-b) +: 8];
    flash_resp3 = resp;
    req3 = 2'b01; addr0_3 = a; addr1_3 = 24'($urandom);
    n = 0;
    while (busy3 && n < 100) begin @(negedge clk); n++; end
    check("idle3_wait_bound", n < 100, 1'b1);
    @(negedge clk);
    k = 1; cur = sck3; run = 1; min_run = 1000; max_run = 0;
    check("cs3_low_t1", cs3_n, 1'b0);
    req3 = 2'b00;
    while (done3 == 2'b00 && k < 1000) begin
      @(negedge clk);
      k++;
      if (done3 == 2'b00) begin
        if (sck3 == cur) run++;
        else begin
          if (run < min_run) min_run = run;
          if (run > max_run) max_run = run;
          cur = sck3; run = 1;
        end
      end
    end
    // The final SCK-high phase ends as done asserts.
    if (run < min_run) min_run = run;
    if (run > max_run) max_run = run;
    check("div3_done_latency", k, LAT3);
    check("div3_min_phase", min_run, CD3);
    check("div3_max_phase", max_run, CD3);
    check("div3_done_grant", done3, 2'b01);
    check("div3_rdata", rdata3, exp_rd);
    check("div3_mosi_cmd_addr", mosi3_cap, {8'h03, a});
    n = 0;
    @(negedge clk);
    while (busy3 && n < 40) begin n++; @(negedge clk); end
    check("div3_gap_length", n, GAP3);
  endtask

  initial begin
    logic       w;
    logic [3:0] order;
    int         n;

    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wp_hold", {wp_n, hold_n}, 2'b11);
    check("rst3_cs_sck_busy", {cs3_n, sck3, busy3}, 3'b100);
    check("rst3_wp_hold", {wp3_n, hold3_n}, 2'b11);
    armed = 1'b1;
    rst = 1'b0;

    // Directed single read.
    run_txn(2'b01, 24'h000100, 24'h0, 32'h11223344, 1'b0, 1'b0, w);
    check("single_rdata_value", rdata, 32'h44332211);

    // Fresh reset, then a held tie: order must alternate starting with 0.
    rst = 1'b1; @(negedge clk); rst = 1'b0; last_grant_m = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 24'($urandom), 24'($urandom), $urandom, i != 3, 1'b0, w);
      order[i] = w;
    end
    check("tie_grant_order", order, 4'b1010);

    // Randomized requests, addresses and flash data.
    for (int i = 0; i < 10; i++)
      run_txn(2'($urandom_range(1, 3)), 24'($urandom), 24'($urandom), $urandom,
              1'b0, 1'($urandom_range(0, 1)), w);

    // Reset at the 40th SCK rise.
    req = 2'b01; addr0 = 24'($urandom); flash_resp = $urandom;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    n = 0;
    while (rise_cnt < 40 && n < 400) begin @(negedge clk); n++; end
    check("reach_rise_40", rise_cnt, 40);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", cs_n, 1'b1);
    check("midrst_sck", sck, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_done", done, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdata", rdata, 32'h0);
    rst = 1'b0; req = 2'b00; last_grant_m = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_rst", done, 2'b00);
    end
    run_txn(2'b11, 24'h00ABCD, 24'h123456, 32'hDEADBEEF, 1'b0, 1'b0, w);
    check("post_rst_tie_winner", w, 1'b0);

    // CLK_DIV=3 instance.
    run_txn3(24'h000100, 32'h11223344);
    run_txn3(24'($urandom), $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1: SCK half-period in clk cycles, legal range 1..15.
REQ-002 SHALL have parameter CS_GAP, default 2: minimum clk cycles flash_spi_cs_n stays high between transactions, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 2: per-requester read request level, bit0 = CPU fetch, bit1 = APU/DMA.
REQ-006 SHALL have port addr0 / addr1, input, 24 each: byte address of the requester's 32-bit read.
REQ-007 SHALL have port done, output, 2: one-cycle completion pulse to the granted requester.
REQ-008 SHALL have port rdata, output, 32: read word, valid in the done cycle and held until the next done.
REQ-009 SHALL have port busy, output, 1: high from grant until GAP exits.
REQ-010 SHALL have ports flash_spi_cs_n, flash_spi_clk and flash_spi_mosi, outputs, 1 each, plus flash_spi_miso, input, 1.
REQ-011 SHALL have ports flash_spi_wp_n and flash_spi_hold_n, outputs, 1 each, tied high.

Function
REQ-012 SHALL implement states IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (32 bits) -> DONE -> GAP -> IDLE.
REQ-013 IDLE SHALL sample req each cycle; with any bit set it latches the winner's address and a grant index, then enters CMD the next cycle.
REQ-014 Arbitration SHALL be round-robin: a single requester wins outright; when both request, the one not granted last wins.
REQ-015 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-016 A request arriving mid-transaction SHALL wait; no preemption.
REQ-017 Every bit SHALL occupy 2*CLK_DIV clk cycles: SCK low for the first CLK_DIV, high for the second.
REQ-018 MOSI SHALL change only while SCK is low, MSB first (SPI mode 0).
REQ-019 The command byte SHALL be 0x03, followed by address bits 23..0.
REQ-020 MISO SHALL be sampled in the clk cycle SCK goes high, during DATA only.
REQ-021 The first received byte SHALL land in rdata[7:0], the fourth in rdata[31:24], each byte MSB first.
REQ-022 With CLK_DIV=1 and req sampled at cycle T: cs_n low and MOSI = cmd bit7 at T+1, 64th SCK rise at T+128, DONE at T+129.
REQ-023 In the DONE cycle: cs_n high, SCK low, rdata updated, done[grant] pulsed.
REQ-024 GAP SHALL hold cs_n high for exactly CS_GAP cycles before IDLE.
REQ-025 Dropping req mid-transaction SHALL NOT abort it; done still pulses and the requester ignores it.
REQ-026 Address changes after grant SHALL be ignored.
REQ-027 done SHALL never be asserted on both bits, nor for more than one cycle.
REQ-028 SCK SHALL be low whenever cs_n is high.

Reset
REQ-029 rst SHALL force IDLE, cs_n=1, SCK=0, MOSI=0, done=0, busy=0, rdata=0 and last-grant=1 on the next clk edge.
REQ-030 rst SHALL take effect mid-transaction: cs_n rises on that edge with no done pulse.
REQ-031 SHALL contain no initial-value reliance; all state comes from rst.

Structure
REQ-032 A shared package flash_pkg SHALL hold the state enum, FLASH_CMD_READ=8'h03 and the bit counts 8/24/32.
REQ-033 A sub-module spi_bit_engine SHALL generate SCK, the 64-bit shift register, the bit counter and MISO sampling.
REQ-034 The arbiter FSM SHALL live in the top module.
REQ-035 RTL SHALL be roughly 150-300 lines total.

Verification
REQ-036 Single read: req=01, addr0=0x000100, flash model returns bytes 11 22 33 44 -> MOSI stream 03 00 01 00, rdata=0x44332211, done=01 at T+129.
REQ-037 Tie: req=11 after reset -> requester 0 served first, then requester 1, with cs_n high exactly CS_GAP cycles between.
REQ-038 Fairness: req=11 held for 4 transactions -> grant order 0,1,0,1.
REQ-039 Reset at the 40th SCK rise -> cs_n=1 next cycle and done stays 0; the next req restarts cleanly from cmd bit7.
REQ-040 CLK_DIV=3 -> SCK high and low phases each 3 clk cycles, done at T+1+384.
REQ-041 Protocol checker SHALL pass for all scenarios: MOSI stable while SCK high, SCK low whenever cs_n=1, done one-hot single-cycle.
